ucdp_afifo_rdstrm: RTL

//  Reader-side companion for ucdp_afifo, clocked in the FIFO target domain.
//  - Drains the FIFO read port (rd_en/rd_data/rd_empty/rd_data_avail) and presents a valid/ready stream.
//  - A 2-entry output buffer keeps ready_i off the rd_en path while sustaining 1 word/cycle.
//  - A watermark gates burst start; a flush discards buffered and queued data.
//

---
 rtl/ucdp_afifo_rdstrm.sv | 90 +++++++++
 1 files changed

// File: rtl/ucdp_afifo_rdstrm.sv
// ucdp_afifo_rdstrm: drains a first-word-fall-through FIFO read port into a 2-entry buffered valid/ready stream
module ucdp_afifo_rdstrm #(
    parameter int dwidth_p = 8,
    parameter int awidth_p = 4
) (
    input  logic                clk_i,
    input  logic                rst_an_i,
    output logic                fifo_rd_en_o,
    input  logic [dwidth_p-1:0] fifo_rd_data_i,
    input  logic                fifo_rd_empty_i,
    input  logic [awidth_p-1:0] fifo_rd_data_avail_i,
    input  logic [awidth_p-1:0] thresh_i,
    input  logic                flush_i,
    output logic                valid_o,
    output logic [dwidth_p-1:0] data_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic [7:0]          drop_cnt_o
);
    typedef enum logic [1:0] {idle_s, xfer_s, flush_s} state_t;

    localparam logic [awidth_p-1:0] depth = awidth_p'(2 ** (awidth_p - 1));

    state_t                state;
    state_t                state_nxt;
    logic   [1:0]          cnt;
    logic   [1:0]          cnt_nxt;
    logic   [dwidth_p-1:0] buf0;
    logic   [dwidth_p-1:0] buf1;
    logic   [awidth_p-1:0] thr;
    logic                  pop;
    logic                  push;
    logic                  hs;

    assign thr     = (thresh_i == '0) ? awidth_p'(1) : (thresh_i > depth) ? depth : thresh_i;
    assign pop     = fifo_rd_en_o & ~fifo_rd_empty_i;
    assign push    = pop & (state == xfer_s);
    assign valid_o = (cnt != 2'd0) & (state != flush_s);
    assign hs      = valid_o & ready_i;
    assign cnt_nxt = flush_i ? 2'd0 : cnt + {1'b0, push} - {1'b0, hs};
    assign data_o  = buf0;
    assign busy_o  = (state != idle_s);

    // next state and FIFO pop request; the pop never looks at ready_i, only at buffer occupancy
    always_comb begin
        state_nxt    = state;
        fifo_rd_en_o = 1'b0;
        case (state)
            idle_s: begin
                if (!fifo_rd_empty_i && fifo_rd_data_avail_i >= thr) state_nxt = xfer_s;
            end
            xfer_s: begin
                fifo_rd_en_o = ~fifo_rd_empty_i & ~cnt[1];
                if (fifo_rd_empty_i && (cnt == 2'd0 || (cnt == 2'd1 && hs))) state_nxt = idle_s;
            end
            flush_s: begin
                fifo_rd_en_o = ~fifo_rd_empty_i;
                if (fifo_rd_empty_i) state_nxt = idle_s;
            end
            default: state_nxt = idle_s;
        endcase
        if (flush_i) state_nxt = flush_s;
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state <= idle_s;
        end else begin
            state <= state_nxt;
        end
    end

    // output buffer (buf0 is the head) and flush drop counter
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            cnt        <= 2'd0;
            buf0       <= '0;
            buf1       <= '0;
            drop_cnt_o <= 8'd0;
        end else begin
            cnt <= cnt_nxt;
            if (hs) buf0 <= (cnt == 2'd1) ? fifo_rd_data_i : buf1;
            else if (push && cnt == 2'd0) buf0 <= fifo_rd_data_i;
            if (push) buf1 <= fifo_rd_data_i;
            if (state == flush_s) drop_cnt_o <= drop_cnt_o + {7'd0, pop & ~&drop_cnt_o};
            else if (flush_i) drop_cnt_o <= {6'd0, cnt} + {7'd0, pop};
        end
    end
endmodule
